// File: rtl/pwm3_center_dt_if.sv
// Phase references, enable, gate drives and carrier observation for pwm3_center_dt.
interface pwm3_center_dt_if #(
    parameter int N     = 24,
    parameter int CNT_W = 16
);
    logic             en;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic [N-1:0]     C;
    logic             a_hi;
    logic             a_lo;
    logic             b_hi;
    logic             b_lo;
    logic             c_hi;
    logic             c_lo;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    modport master (
        output en, A, B, C,
        input  a_hi, a_lo, b_hi, b_lo, c_hi, c_lo, sync, cnt
    );

    modport slave (
        input  en, A, B, C,
        output a_hi, a_lo, b_hi, b_lo, c_hi, c_lo, sync, cnt
    );
endinterface

// File: rtl/pwm3_center_dt.sv
// Three-phase center-aligned PWM with valley-committed compare values and
// per-leg dead-time insertion; references are sign-magnitude Q-format words.
module pwm3_center_dt #(
    parameter int N        = 24,
    parameter int Q        = 12,
    parameter int CNT_W    = 16,
    parameter int PERIOD   = 2500,
    parameter int DEADTIME = 100
) (
    input  logic            clk,
    input  logic            rst,
    pwm3_center_dt_if.slave bus
);
    localparam int UW = Q + 2;
    localparam int PW = UW + CNT_W;
    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(PERIOD / 2);
    localparam logic [CNT_W-1:0] DT_C     = CNT_W'(DEADTIME);
    localparam logic [UW-1:0]    ONE_U    = UW'(1) << Q;
    localparam logic [N-2:0]     ONE_MAG  = (N-1)'(1) << Q;

    logic [CNT_W-1:0] cnt_reg;
    logic             dir_up_reg;
    logic             s1_valid_reg;
    logic             peak;
    logic             valley;
    logic [N-1:0]     ref_in [3];
    logic [2:0]       hi_vec;
    logic [2:0]       lo_vec;

    assign peak      = bus.en & (cnt_reg == PERIOD_C);
    assign valley    = bus.en & (cnt_reg == '0);
    assign ref_in[0] = bus.A;
    assign ref_in[1] = bus.B;
    assign ref_in[2] = bus.C;

    // Triangle carrier: 0 .. PERIOD .. 1, then back to 0
    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            cnt_reg    <= '0;
            dir_up_reg <= 1'b1;
        end else if (dir_up_reg) begin
            if (cnt_reg == PERIOD_C) begin
                cnt_reg    <= PERIOD_C - CNT_W'(1);
                dir_up_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end else begin
            if (cnt_reg == CNT_W'(1)) begin
                cnt_reg    <= '0;
                dir_up_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= peak;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_phase
            logic [N-2:0]     mag;
            logic [Q:0]       m_clamp;
            logic [UW-1:0]    u_next;
            logic [UW-1:0]    u_reg;
            logic [PW-1:0]    prod;
            logic [CNT_W-1:0] stage_reg;
            logic [CNT_W-1:0] cmp_reg;
            logic             raw_reg;
            logic             raw_q_reg;
            logic [CNT_W-1:0] dt_reg;
            logic [CNT_W-1:0] dt_next;
            logic             hi_next;
            logic             lo_next;
            logic             hi_reg;
            logic             lo_reg;

            always_comb begin
                mag     = ref_in[gi][N-2:0];
                m_clamp = (mag > ONE_MAG) ? ONE_MAG[Q:0] : mag[Q:0];
                // Offset-binary duty: 0 = full negative, 2*ONE = full positive
                u_next  = ref_in[gi][N-1] ? (ONE_U - UW'(m_clamp)) : (ONE_U + UW'(m_clamp));
                prod    = PW'(u_reg) * PW'(PERIOD_C);

                if (!bus.en || (raw_reg != raw_q_reg)) begin
                    dt_next = DT_C;
                end else if (dt_reg != '0) begin
                    dt_next = dt_reg - CNT_W'(1);
                end else begin
                    dt_next = dt_reg;
                end
                // A reload never yields zero, so a raw edge always blanks both gates
                hi_next = bus.en &  raw_reg & (dt_next == '0);
                lo_next = bus.en & ~raw_reg & (dt_next == '0);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    u_reg     <= ONE_U;
                    stage_reg <= HALF_C;
                    cmp_reg   <= HALF_C;
                    raw_reg   <= 1'b0;
                    raw_q_reg <= 1'b0;
                    dt_reg    <= DT_C;
                    hi_reg    <= 1'b0;
                    lo_reg    <= 1'b0;
                end else begin
                    if (peak) begin
                        u_reg <= u_next;
                    end
                    if (s1_valid_reg) begin
                        stage_reg <= CNT_W'(prod >> (Q + 1));
                    end
                    if (valley) begin
                        cmp_reg <= stage_reg;
                    end
                    raw_reg   <= (cmp_reg >= PERIOD_C) | (cnt_reg < cmp_reg);
                    raw_q_reg <= raw_reg;
                    dt_reg    <= dt_next;
                    hi_reg    <= hi_next;
                    lo_reg    <= lo_next;
                end
            end

            assign hi_vec[gi] = hi_reg;
            assign lo_vec[gi] = lo_reg;
        end
    endgenerate

    assign bus.a_hi = hi_vec[0];
    assign bus.a_lo = lo_vec[0];
    assign bus.b_hi = hi_vec[1];
    assign bus.b_lo = lo_vec[1];
    assign bus.c_hi = hi_vec[2];
    assign bus.c_lo = lo_vec[2];
    assign bus.sync = valley & ~rst;
    assign bus.cnt  = cnt_reg;
endmodule
